micro_sequencer: RTL and testbench

//  Microprogram sequencer for the bus-based microcoded RISC-V core. Holds the micro-PC (uPC).
//  uPC drives the 6-bit select of the 64-entry x 32-bit microinstruction mux (control store).
//  The selected microinstruction returns ubr/utarget, so the next-uPC loop closes through that mux.

---
 rtl/micro_sequencer.sv | 89 ++++++++
 tb/tb_micro_sequencer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer holding the uPC for a microcoded RISC-V core
// Ports: clk, rst (sync, active-high), en (advance enable), ubr (branch type),
//   utarget (jump target), zero (ALU flag), mem_busy (bus busy), opcode (IR[6:0]),
//   upc (registered uPC), spin (comb. memory wait), illegal / ubr_err (1-cycle pulses).
// Optional feature: define UCALL_EN for a one-entry CALL/RET return register.
module micro_sequencer #(
  parameter int UADDR_WIDTH = 6,
  parameter logic [UADDR_WIDTH-1:0] FETCH_ADDR = '0,
  parameter logic [UADDR_WIDTH-1:0] ILLEGAL_ADDR = UADDR_WIDTH'(62)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [2:0]             ubr,
  input  logic [UADDR_WIDTH-1:0] utarget,
  input  logic                   zero,
  input  logic                   mem_busy,
  input  logic [6:0]             opcode,
  output logic [UADDR_WIDTH-1:0] upc,
  output logic                   spin,
  output logic                   illegal,
  output logic                   ubr_err
);
  logic [UADDR_WIDTH-1:0] inc, disp, nxt;
  logic known, err_n;
`ifdef UCALL_EN
  logic [UADDR_WIDTH-1:0] ret_reg;
`endif
  assign inc = upc + 1'b1;
  assign spin = en & (ubr == 3'd5) & mem_busy;
  always_comb begin
    disp = ILLEGAL_ADDR;
    known = 1'b1;
    case (opcode)
      7'b0000011: disp = UADDR_WIDTH'(8);
      7'b0100011: disp = UADDR_WIDTH'(12);
      7'b0010011: disp = UADDR_WIDTH'(16);
      7'b0110011: disp = UADDR_WIDTH'(20);
      7'b1100011: disp = UADDR_WIDTH'(24);
      7'b1101111: disp = UADDR_WIDTH'(28);
      7'b1100111: disp = UADDR_WIDTH'(32);
      7'b0110111: disp = UADDR_WIDTH'(36);
      7'b0010111: disp = UADDR_WIDTH'(40);
      default:    known = 1'b0;
    endcase
  end
  always_comb begin
    nxt = inc;
    err_n = 1'b0;
    case (ubr)
      3'd0: nxt = inc;
      3'd1: nxt = utarget;
      3'd2: nxt = zero ? utarget : inc;
      3'd3: nxt = zero ? inc : utarget;
      3'd4: nxt = disp;
      3'd5: nxt = mem_busy ? upc : inc;
`ifdef UCALL_EN
      3'd6: nxt = utarget;
      default: nxt = ret_reg;
`else
      // reserved codes restart the fetch routine and flag the fault
      default: begin
        nxt = FETCH_ADDR;
        err_n = 1'b1;
      end
`endif
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      upc <= FETCH_ADDR;
      illegal <= 1'b0;
      ubr_err <= 1'b0;
`ifdef UCALL_EN
      ret_reg <= '0;
`endif
    end else if (!en) begin
      illegal <= 1'b0;
      ubr_err <= 1'b0;
    end else begin
      upc <= nxt;
      illegal <= (ubr == 3'd4) & ~known;
      ubr_err <= err_n;
`ifdef UCALL_EN
      if (ubr == 3'd6) ret_reg <= inc;
`endif
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed scoreboard bench for micro_sequencer
module tb_micro_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b1, zero = 1'b0, mem_busy = 1'b0;
  logic [2:0] ubr = 3'd0;
  logic [5:0] utarget = 6'd0;
  logic [6:0] opcode = 7'd0;
  logic [5:0] upc;
  logic spin, illegal, ubr_err;
  int tests = 0, fails = 0;
  typedef struct {
    logic [5:0] upc;
    logic ill;
    logic err;
    logic spn;
    string name;
  } exp_t;
  exp_t q[$];

  micro_sequencer dut (
    .clk(clk), .rst(rst), .en(en), .ubr(ubr), .utarget(utarget), .zero(zero),
    .mem_busy(mem_busy), .opcode(opcode), .upc(upc), .spin(spin),
    .illegal(illegal), .ubr_err(ubr_err)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [2:0] b,
                      input logic [5:0] t, input logic z, input logic m,
                      input logic [6:0] o, input logic [5:0] eu, input logic ei,
                      input logic ee, input logic es, input string nm);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; ubr = b; utarget = t; zero = z; mem_busy = m; opcode = o;
    x.upc = eu; x.ill = ei; x.err = ee; x.spn = es; x.name = nm;
    q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      tests += 4;
      if (upc !== x.upc) begin
        fails++;
        $display("FAIL %s upc got %0d expected %0d", x.name, upc, x.upc);
      end
      if (illegal !== x.ill) begin
        fails++;
        $display("FAIL %s illegal got %b expected %b", x.name, illegal, x.ill);
      end
      if (ubr_err !== x.err) begin
        fails++;
        $display("FAIL %s ubr_err got %b expected %b", x.name, ubr_err, x.err);
      end
      if (spin !== x.spn) begin
        fails++;
        $display("FAIL %s spin got %b expected %b", x.name, spin, x.spn);
      end
    end
  end

  initial begin
    //    rst en ubr tgt z  busy opcode        upc ill err spin
    step(1, 1, 0, 0,  0, 0, 7'd0,          0,  0, 0, 0, "t1_rst0");
    step(1, 1, 0, 0,  0, 0, 7'd0,          0,  0, 0, 0, "t1_rst1");
    step(0, 1, 0, 0,  0, 0, 7'd0,          1,  0, 0, 0, "t1_n1");
    step(0, 1, 0, 0,  0, 0, 7'd0,          2,  0, 0, 0, "t1_n2");
    step(0, 1, 0, 0,  0, 0, 7'd0,          3,  0, 0, 0, "t1_n3");
    step(0, 1, 1, 2,  0, 0, 7'd0,          2,  0, 0, 0, "t2_j2");
    step(0, 1, 4, 0,  0, 0, 7'b0110011,    20, 0, 0, 0, "t2_d_op");
    step(0, 1, 4, 0,  0, 0, 7'b1111111,    62, 1, 0, 0, "t2_d_bad");
    step(0, 1, 0, 0,  0, 0, 7'd0,          63, 0, 0, 0, "t2_ill_clr");
    step(0, 1, 0, 0,  0, 0, 7'd0,          0,  0, 0, 0, "t5_wrap");
    step(0, 1, 4, 0,  0, 0, 7'b0000011,    8,  0, 0, 0, "t2_d_load");
    step(0, 1, 4, 0,  0, 0, 7'b1101111,    28, 0, 0, 0, "t2_d_jal");
    step(0, 1, 4, 0,  0, 0, 7'b0110111,    36, 0, 0, 0, "t2_d_lui");
    step(0, 1, 4, 0,  0, 0, 7'b0010111,    40, 0, 0, 0, "t2_d_auipc");
    step(0, 1, 4, 0,  0, 0, 7'b0100011,    12, 0, 0, 0, "t2_d_store");
    step(0, 1, 1, 10, 0, 0, 7'd0,          10, 0, 0, 0, "t3_j10");
    step(0, 1, 5, 0,  0, 1, 7'd0,          10, 0, 0, 1, "t3_spin1");
    step(0, 1, 5, 0,  0, 1, 7'd0,          10, 0, 0, 1, "t3_spin2");
    step(0, 1, 5, 0,  0, 1, 7'd0,          10, 0, 0, 1, "t3_spin3");
    step(0, 1, 5, 0,  0, 0, 7'd0,          11, 0, 0, 0, "t3_go");
    step(0, 1, 2, 45, 1, 0, 7'd0,          45, 0, 0, 0, "t4_ez_t");
    step(0, 1, 2, 45, 0, 0, 7'd0,          46, 0, 0, 0, "t4_ez_f");
    step(0, 1, 3, 45, 0, 0, 7'd0,          45, 0, 0, 0, "t4_nz_t");
    step(0, 1, 3, 45, 1, 0, 7'd0,          46, 0, 0, 0, "t4_nz_f");
    step(0, 1, 1, 63, 0, 0, 7'd0,          63, 0, 0, 0, "t5_j63");
    step(0, 1, 0, 0,  0, 0, 7'd0,          0,  0, 0, 0, "t5_wrap2");
    step(0, 0, 1, 7,  0, 0, 7'd0,          0,  0, 0, 0, "t5_hold");
    step(0, 1, 4, 0,  0, 0, 7'b0000000,    62, 1, 0, 0, "t5_d_bad");
    step(0, 0, 4, 0,  0, 0, 7'b0000000,    62, 0, 0, 0, "t5_hold_clr");
    step(0, 0, 5, 0,  0, 1, 7'd0,          62, 0, 0, 0, "t5_hold_nospin");
    step(0, 1, 1, 10, 0, 0, 7'd0,          10, 0, 0, 0, "t5_j10");
    step(0, 1, 5, 0,  0, 1, 7'd0,          10, 0, 0, 1, "t5_spin");
    step(1, 1, 5, 0,  0, 1, 7'd0,          0,  0, 0, 1, "t5_rst_spin");
    step(0, 1, 0, 0,  0, 0, 7'd0,          1,  0, 0, 0, "t5_after_rst");
    step(0, 1, 1, 5,  0, 0, 7'd0,          5,  0, 0, 0, "t6_j5");
`ifdef UCALL_EN
    step(0, 1, 6, 50, 0, 0, 7'd0,          50, 0, 0, 0, "t6_call");
    step(0, 1, 7, 0,  0, 0, 7'd0,          6,  0, 0, 0, "t6_ret");
    step(0, 1, 6, 20, 0, 0, 7'd0,          20, 0, 0, 0, "t6_call2");
    step(0, 1, 7, 0,  0, 0, 7'd0,          7,  0, 0, 0, "t6_ret2");
`else
    step(0, 1, 6, 50, 0, 0, 7'd0,          0,  0, 1, 0, "t6_call_err");
    step(0, 1, 0, 0,  0, 0, 7'd0,          1,  0, 0, 0, "t6_err_clr");
    step(0, 1, 7, 50, 0, 0, 7'd0,          0,  0, 1, 0, "t6_ret_err");
    step(0, 0, 0, 0,  0, 0, 7'd0,          0,  0, 0, 0, "t6_hold_clr");
`endif
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
